// File: rtl/video_mem_port.sv
// ---------------------------------------------------------------------------
// video_mem_port
//
// Shared video memory (8 KiB VRAM + 160-byte OAM) with a display read port
// and a CPU read/write port. The display port always wins an array in any
// cycle where that array's output enable is high. A CPU write that collides
// with the display is parked in a one-entry write buffer and retired at the
// first edge the target array is free. While the buffer is full, further
// CPU writes are stalled with cpu_wait.
//
// Optional feature macro: VIDEO_MEM_MODE_LOCK_EN
//   Defined:   mode 11 locks VRAM and OAM against CPU access, mode 10 locks
//              OAM only. Locked writes are dropped and locked reads give FF.
//   Undefined: mode is ignored.
//
// Ports
//   clk_cpu          in   1   clock, all state on rising edge
//   rst              in   1   synchronous active-high reset
//   rd_address       in  13   display read address (OAM index in [7:0])
//   ld_address_vram  in   1   latch rd_address into the VRAM read pointer
//   ld_address_oam   in   1   latch rd_address[7:0] into the OAM read pointer
//   oe_vram          in   1   drive VRAM byte on read_data, VRAM busy
//   oe_oam           in   1   drive OAM byte on read_data, OAM busy
//   read_data        out  8   display read data
//   mode             in   2   display mode (used only with the lock macro)
//   cpu_addr         in  16   CPU address
//   cpu_rd           in   1   CPU read strobe
//   cpu_wr           in   1   CPU write strobe (wins over cpu_rd)
//   cpu_wdata        in   8   CPU write data
//   cpu_rdata        out  8   CPU read data (combinational)
//   cpu_wait         out  1   write buffer full, CPU must hold its write
// ---------------------------------------------------------------------------
module video_mem_port (
    input  logic        clk_cpu,
    input  logic        rst,
    input  logic [12:0] rd_address,
    input  logic        ld_address_vram,
    input  logic        ld_address_oam,
    input  logic        oe_vram,
    input  logic        oe_oam,
    output logic [7:0]  read_data,
    input  logic [1:0]  mode,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait
);

    localparam int          VRAM_DEPTH = 8192;
    localparam int          OAM_DEPTH  = 160;
    localparam logic [7:0]  OAM_SIZE   = 8'd160;

    typedef enum logic { ST_IDLE, ST_PENDING } state_t;
    typedef enum logic { TGT_VRAM, TGT_OAM } tgt_t;

    // Storage
    logic [7:0] vram_q [VRAM_DEPTH];
    logic [7:0] oam_q  [OAM_DEPTH];

    // Display read pointers
    logic [12:0] vaddr_q;
    logic [7:0]  oaddr_q;

    // FSM; ST_PENDING doubles as the write-buffer valid flag
    state_t state_q, state_d;

    // One-entry write buffer
    logic [12:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    tgt_t        buf_tgt_q,  buf_tgt_d;

    // Array write ports
    logic        vram_we;
    logic [12:0] vram_waddr;
    logic [7:0]  vram_wdata;
    logic        oam_we;
    logic [7:0]  oam_waddr;
    logic [7:0]  oam_wdata;

    // ------------------------------------------------------------------
    // Address decode and array status
    // ------------------------------------------------------------------
    logic cpu_is_vram, cpu_is_oam, cpu_is_unusable;
    logic vram_busy, oam_busy;
    logic vram_lock, oam_lock;

    assign cpu_is_vram     = (cpu_addr[15:13] == 3'b100);
    assign cpu_is_oam      = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] < OAM_SIZE);
    assign cpu_is_unusable = (cpu_addr[15:8] == 8'hFE) && (cpu_addr[7:0] >= OAM_SIZE);

    assign vram_busy = oe_vram;
    assign oam_busy  = oe_oam;

`ifdef VIDEO_MEM_MODE_LOCK_EN
    assign vram_lock = (mode == 2'b11);
    assign oam_lock  = mode[1];
`else
    logic unused_mode;
    assign unused_mode = ^mode;
    assign vram_lock   = 1'b0;
    assign oam_lock    = 1'b0;
`endif

    // A write that may touch an array at all (mapped and not locked)
    logic wr_vram_ok, wr_oam_ok;
    assign wr_vram_ok = cpu_wr && cpu_is_vram && !vram_lock;
    assign wr_oam_ok  = cpu_wr && cpu_is_oam  && !oam_lock;

    // Buffer retires this edge; a write to the other, free array may go
    // straight through on that same edge without stalling.
    logic retire, other_ok;
    assign retire   = (state_q == ST_PENDING) &&
                      ((buf_tgt_q == TGT_VRAM) ? !vram_busy : !oam_busy);
    assign other_ok = retire &&
                      ((buf_tgt_q == TGT_VRAM) ? (wr_oam_ok && !oam_busy)
                                               : (wr_vram_ok && !vram_busy));

    // ------------------------------------------------------------------
    // Next-state, write-port and stall logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        buf_tgt_d  = buf_tgt_q;
        vram_we    = 1'b0;
        vram_waddr = cpu_addr[12:0];
        vram_wdata = cpu_wdata;
        oam_we     = 1'b0;
        oam_waddr  = cpu_addr[7:0];
        oam_wdata  = cpu_wdata;
        cpu_wait   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wr_vram_ok) begin
                    if (vram_busy) begin
                        buf_addr_d = cpu_addr[12:0];
                        buf_data_d = cpu_wdata;
                        buf_tgt_d  = TGT_VRAM;
                        state_d    = ST_PENDING;
                    end else begin
                        vram_we = 1'b1;
                    end
                end else if (wr_oam_ok) begin
                    if (oam_busy) begin
                        buf_addr_d = {5'b0, cpu_addr[7:0]};
                        buf_data_d = cpu_wdata;
                        buf_tgt_d  = TGT_OAM;
                        state_d    = ST_PENDING;
                    end else begin
                        oam_we = 1'b1;
                    end
                end
            end

            ST_PENDING: begin
                cpu_wait = cpu_wr && !other_ok;
                if (retire) begin
                    state_d = ST_IDLE;
                    if (buf_tgt_q == TGT_VRAM) begin
                        vram_we    = 1'b1;
                        vram_waddr = buf_addr_q;
                        vram_wdata = buf_data_q;
                        oam_we     = other_ok;
                    end else begin
                        oam_we     = 1'b1;
                        oam_waddr  = buf_addr_q[7:0];
                        oam_wdata  = buf_data_q;
                        vram_we    = other_ok;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Reset freezes the arrays and releases the CPU
        if (rst) begin
            vram_we  = 1'b0;
            oam_we   = 1'b0;
            cpu_wait = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_cpu) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            vaddr_q <= '0;
            oaddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (ld_address_vram) vaddr_q <= rd_address;
            if (ld_address_oam)  oaddr_q <= rd_address[7:0];
        end
    end

    // Buffer payload is meaningless unless ST_PENDING, so it needs no reset
    always_ff @(posedge clk_cpu) begin
        buf_addr_q <= buf_addr_d;
        buf_data_q <= buf_data_d;
        buf_tgt_q  <= buf_tgt_d;
    end

    // NOTE: the storage arrays are deliberately not reset; contents survive
    // rst and a reset port on a memory would prevent RAM inference.
    always_ff @(posedge clk_cpu) begin
        if (vram_we) vram_q[vram_waddr] <= vram_wdata;
    end

    always_ff @(posedge clk_cpu) begin
        if (oam_we) oam_q[oam_waddr] <= oam_wdata;
    end

    // ------------------------------------------------------------------
    // Display read port
    // ------------------------------------------------------------------
    always_comb begin
        read_data = 8'hFF;
        if (!rst) begin
            if (oe_vram) begin
                read_data = vram_q[vaddr_q];
            end else if (oe_oam && (oaddr_q < OAM_SIZE)) begin
                read_data = oam_q[oaddr_q];
            end
        end
    end

    // ------------------------------------------------------------------
    // CPU read port; the buffered byte shadows the array until it retires
    // ------------------------------------------------------------------
    logic fwd_vram, fwd_oam;
    assign fwd_vram = (state_q == ST_PENDING) && (buf_tgt_q == TGT_VRAM) &&
                      (buf_addr_q == cpu_addr[12:0]);
    assign fwd_oam  = (state_q == ST_PENDING) && (buf_tgt_q == TGT_OAM) &&
                      (buf_addr_q == {5'b0, cpu_addr[7:0]});

    always_comb begin
        cpu_rdata = 8'hFF;
        if (!rst && cpu_rd && !cpu_wr) begin
            if (cpu_is_vram) begin
                if (!vram_busy && !vram_lock) begin
                    cpu_rdata = fwd_vram ? buf_data_q : vram_q[cpu_addr[12:0]];
                end
            end else if (cpu_is_oam) begin
                if (!oam_busy && !oam_lock) begin
                    cpu_rdata = fwd_oam ? buf_data_q : oam_q[cpu_addr[7:0]];
                end
            end else if (cpu_is_unusable) begin
                cpu_rdata = 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_video_mem_port.sv
// ---------------------------------------------------------------------------
// tb_video_mem_port
//
// Directed bench for video_mem_port. Stimulus is applied 1 ns after each
// rising edge and the expected values for that cycle are queued; a monitor
// on the falling edge pops the queue and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_video_mem_port;

    logic        clk_cpu;
    logic        rst;
    logic [12:0] rd_address;
    logic        ld_address_vram;
    logic        ld_address_oam;
    logic        oe_vram;
    logic        oe_oam;
    logic [7:0]  read_data;
    logic [1:0]  mode;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;

    video_mem_port dut (
        .clk_cpu         (clk_cpu),
        .rst             (rst),
        .rd_address      (rd_address),
        .ld_address_vram (ld_address_vram),
        .ld_address_oam  (ld_address_oam),
        .oe_vram         (oe_vram),
        .oe_oam          (oe_oam),
        .read_data       (read_data),
        .mode            (mode),
        .cpu_addr        (cpu_addr),
        .cpu_rd          (cpu_rd),
        .cpu_wr          (cpu_wr),
        .cpu_wdata       (cpu_wdata),
        .cpu_rdata       (cpu_rdata),
        .cpu_wait        (cpu_wait)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef enum int { SIG_READ_DATA, SIG_CPU_RDATA, SIG_CPU_WAIT } sig_e;

    typedef struct {
        string      name;
        sig_e       sig;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_sig(input string name, input sig_e sig, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = val;
        sb.push_back(e);
    endtask

    exp_t mon_e;
    always @(negedge clk_cpu) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            case (mon_e.sig)
                SIG_READ_DATA: check(mon_e.name, read_data, mon_e.exp);
                SIG_CPU_RDATA: check(mon_e.name, cpu_rdata, mon_e.exp);
                default:       check(mon_e.name, {7'b0, cpu_wait}, mon_e.exp);
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk_cpu);
        #1;
        rst             = 1'b0;
        rd_address      = '0;
        ld_address_vram = 1'b0;
        ld_address_oam  = 1'b0;
        oe_vram         = 1'b0;
        oe_oam          = 1'b0;
        mode            = 2'b00;
        cpu_addr        = '0;
        cpu_rd          = 1'b0;
        cpu_wr          = 1'b0;
        cpu_wdata       = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a);
        cpu_addr = a;
        cpu_rd   = 1'b1;
    endtask

    // Cycle that only writes a byte with no display activity
    task automatic seed(input logic [15:0] a, input logic [7:0] d);
        cyc();
        wr(a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; rd_address = '0; ld_address_vram = 1'b0; ld_address_oam = 1'b0;
        oe_vram = 1'b0; oe_oam = 1'b0; mode = 2'b00; cpu_addr = '0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;

        // Outputs held quiet during reset
        cyc(); rst = 1'b1; oe_vram = 1'b1; rd(16'h8000);
        expect_sig("rst_read_data", SIG_READ_DATA, 8'hFF);
        expect_sig("rst_cpu_rdata", SIG_CPU_RDATA, 8'hFF);
        expect_sig("rst_cpu_wait",  SIG_CPU_WAIT,  8'h00);
        cyc(); rst = 1'b1;
        cyc();
        expect_sig("idle_read_data", SIG_READ_DATA, 8'hFF);

        // Seed known contents
        seed(16'h8000, 8'hA7);
        expect_sig("direct_write_no_wait", SIG_CPU_WAIT, 8'h00);
        seed(16'h9800, 8'h11);
        seed(16'h9801, 8'h22);
        seed(16'h8005, 8'hC3);
        seed(16'h8040, 8'h0F);
        seed(16'hFE00, 8'h5C);
        seed(16'hFE05, 8'h12);

        // Direct write then display read through latched pointer
        seed(16'h8010, 8'h3C);
        cyc(); ld_address_vram = 1'b1; rd_address = 13'h0010;
        cyc(); oe_vram = 1'b1; rd(16'h8010);
        expect_sig("disp_vram_8010", SIG_READ_DATA, 8'h3C);
        expect_sig("cpu_rd_vram_busy", SIG_CPU_RDATA, 8'hFF);
        cyc(); rd(16'h8010);
        expect_sig("cpu_rd_8010", SIG_CPU_RDATA, 8'h3C);

        // Write collides with display, buffered, stalls a second write
        cyc(); oe_vram = 1'b1; wr(16'h9800, 8'h5A);
        expect_sig("capture_no_wait", SIG_CPU_WAIT, 8'h00);
        cyc(); oe_vram = 1'b1; wr(16'h9801, 8'h99);
        expect_sig("pending_wait", SIG_CPU_WAIT, 8'h01);
        cyc(); oe_vram = 1'b1; rd(16'h9800);
        expect_sig("pending_busy_rd", SIG_CPU_RDATA, 8'hFF);
        expect_sig("pending_rd_no_wait", SIG_CPU_WAIT, 8'h00);
        cyc(); rd(16'h9800);
        expect_sig("forward_9800", SIG_CPU_RDATA, 8'h5A);
        cyc(); rd(16'h9800);
        expect_sig("retired_9800", SIG_CPU_RDATA, 8'h5A);
        cyc(); rd(16'h9801);
        expect_sig("stalled_not_written", SIG_CPU_RDATA, 8'h22);
        cyc(); wr(16'h9802, 8'h33);
        expect_sig("idle_after_retire", SIG_CPU_WAIT, 8'h00);
        cyc(); rd(16'h9802);
        expect_sig("rd_9802", SIG_CPU_RDATA, 8'h33);
        cyc(); ld_address_vram = 1'b1; rd_address = 13'h1800;
        cyc(); oe_vram = 1'b1;
        expect_sig("disp_vram_1800", SIG_READ_DATA, 8'h5A);

        // Retire edge accepts a write to the other array
        cyc(); oe_oam = 1'b1; wr(16'hFE10, 8'h44);
        expect_sig("oam_capture_no_wait", SIG_CPU_WAIT, 8'h00);
        cyc(); wr(16'h8020, 8'h55);
        expect_sig("retire_other_no_wait", SIG_CPU_WAIT, 8'h00);
        cyc(); rd(16'hFE10);
        expect_sig("oam_retired", SIG_CPU_RDATA, 8'h44);
        cyc(); rd(16'h8020);
        expect_sig("other_written", SIG_CPU_RDATA, 8'h55);

`ifdef VIDEO_MEM_MODE_LOCK_EN
        // Mode locks
        cyc(); mode = 2'b10; wr(16'hFE05, 8'h77);
        cyc(); mode = 2'b10; rd(16'hFE05);
        expect_sig("lock10_oam_rd", SIG_CPU_RDATA, 8'hFF);
        cyc(); mode = 2'b00; rd(16'hFE05);
        expect_sig("lock10_oam_unchanged", SIG_CPU_RDATA, 8'h12);
        cyc(); mode = 2'b10; oe_oam = 1'b1; wr(16'hFE05, 8'h66);
        cyc(); mode = 2'b10; wr(16'h8031, 8'h01);
        expect_sig("locked_not_buffered", SIG_CPU_WAIT, 8'h00);
        cyc(); mode = 2'b00; wr(16'hFE05, 8'h77);
        cyc(); rd(16'hFE05);
        expect_sig("mode00_oam_write", SIG_CPU_RDATA, 8'h77);
        cyc(); mode = 2'b11; wr(16'h8031, 8'h02);
        cyc(); mode = 2'b11; rd(16'h8031);
        expect_sig("lock11_vram_rd", SIG_CPU_RDATA, 8'hFF);
        cyc(); rd(16'h8031);
        expect_sig("lock11_vram_unchanged", SIG_CPU_RDATA, 8'h01);
`else
        // Mode has no effect
        cyc(); mode = 2'b10; wr(16'hFE05, 8'h77);
        cyc(); mode = 2'b11; rd(16'hFE05);
        expect_sig("mode_ignored_oam", SIG_CPU_RDATA, 8'h77);
        cyc(); mode = 2'b11; wr(16'h8031, 8'h02);
        cyc(); mode = 2'b11; rd(16'h8031);
        expect_sig("mode_ignored_vram", SIG_CPU_RDATA, 8'h02);
`endif

        // OAM index out of range, unusable region, both-pointer latch
        cyc(); ld_address_oam = 1'b1; rd_address = 13'h00A5;
        cyc(); oe_oam = 1'b1; rd(16'hFEA3);
        expect_sig("oam_idx_a5", SIG_READ_DATA, 8'hFF);
        expect_sig("unusable_rd", SIG_CPU_RDATA, 8'h00);
        cyc(); ld_address_oam = 1'b1; ld_address_vram = 1'b1; rd_address = 13'h0005;
        cyc(); oe_vram = 1'b1; oe_oam = 1'b1;
        expect_sig("oe_vram_wins", SIG_READ_DATA, 8'hC3);
        cyc(); oe_oam = 1'b1; rd(16'hC000);
        expect_sig("disp_oam_5", SIG_READ_DATA, 8'h77);
        expect_sig("unmapped_rd", SIG_CPU_RDATA, 8'hFF);

        // rd and wr together act as a write
        cyc(); rd(16'h8050); wr(16'h8050, 8'h9D);
        cyc(); rd(16'h8050);
        expect_sig("rd_wr_is_write", SIG_CPU_RDATA, 8'h9D);

        // Reset discards a pending write and clears the pointers
        cyc(); oe_vram = 1'b1; wr(16'h8040, 8'hBE);
        expect_sig("pre_rst_capture", SIG_CPU_WAIT, 8'h00);
        cyc(); rst = 1'b1; oe_vram = 1'b1; wr(16'h8041, 8'h00);
        expect_sig("rst_pending_wait", SIG_CPU_WAIT, 8'h00);
        expect_sig("rst_pending_rdata", SIG_READ_DATA, 8'hFF);
        cyc(); wr(16'h8042, 8'h44);
        expect_sig("post_rst_idle", SIG_CPU_WAIT, 8'h00);
        cyc(); rd(16'h8040);
        expect_sig("discarded_write", SIG_CPU_RDATA, 8'h0F);
        cyc(); oe_vram = 1'b1;
        expect_sig("vaddr_reset", SIG_READ_DATA, 8'hA7);
        cyc(); oe_oam = 1'b1;
        expect_sig("oaddr_reset", SIG_READ_DATA, 8'h5C);

        cyc();
        cyc();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_cpu);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
